// File: rtl/sel_mux_gate.sv
// Registered select-and-gate output stage: per-channel two-source mux, enable mask,
// blanking window after every select change, idle flag and saturating activation count.
module sel_mux_gate #(
  parameter int                 NCH      = 4,
  parameter int                 GUARD    = 2,
  parameter logic [NCH-1:0]     MASK_RST = {NCH{1'b1}},
  parameter int                 CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [NCH-1:0]   src_a,
  input  logic [NCH-1:0]   src_b,
  input  logic             mask_wr,
  input  logic [NCH-1:0]   mask_data,
  input  logic             cnt_clr,
  output logic [NCH-1:0]   out,
  output logic             idle,
  output logic             busy,
  output logic [NCH-1:0]   mask,
  output logic [CNT_W-1:0] act_cnt
);

  localparam logic [3:0] GUARD_LD = 4'(GUARD);

  logic             sel_q, sel_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   out_q, out_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d;

  logic             chg;
  logic [NCH-1:0]   src_sel;
  logic             act_evt;

  assign chg     = (sel != sel_q);
  assign src_sel = sel_q ? src_a : src_b;

  // Window handling: a select change always (re)loads the guard and blanks this edge.
  always_comb begin
    sel_d  = sel_q;
    gcnt_d = gcnt_q;
    out_d  = out_q;
    if (chg) begin
      sel_d  = sel;
      gcnt_d = GUARD_LD;
      out_d  = '0;
    end else if (gcnt_q != 4'd0) begin
      gcnt_d = gcnt_q - 4'd1;
      out_d  = '0;
    end else begin
      out_d  = src_sel & mask_q;
    end
  end

  // Old mask gates this edge; a written mask only affects the following edge.
  always_comb begin
    mask_d = mask_q;
    if (mask_wr) begin
      mask_d = mask_data;
    end
  end

  assign act_evt = (out_q == '0) && (out_d != '0);

  always_comb begin
    act_cnt_d = act_cnt_q;
    if (cnt_clr) begin
      act_cnt_d = '0;
    end else if (act_evt && (act_cnt_q != {CNT_W{1'b1}})) begin
      act_cnt_d = act_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      gcnt_q    <= 4'd0;
      mask_q    <= MASK_RST;
      out_q     <= '0;
      act_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      gcnt_q    <= gcnt_d;
      mask_q    <= mask_d;
      out_q     <= out_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign out     = out_q;
  assign idle    = (out_q == '0);
  assign busy    = (gcnt_q != 4'd0);
  assign mask    = mask_q;
  assign act_cnt = act_cnt_q;

endmodule
